// File: rtl/fbeb_param.sv
// Parametrised full-bandwidth elastic buffer: DEPTH single-entry slots addressed
// round-robin by head/tail pointers, with registered occupancy, almost-full and flush.
module fbeb_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 5,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter int PTR_W        = $clog2(DEPTH),
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  up_vld,
    output logic                  up_rdy,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  dn_vld,
    input  logic                  dn_rdy,
    output logic [DATA_WIDTH-1:0] dn_data,
    output logic [CNT_W-1:0]      count,
    output logic                  almost_full
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0]      slot_vld;
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      count_nxt;

    // Readiness comes only from slot flops and flush, so dn_rdy never reaches up_rdy.
    assign up_rdy    = ~slot_vld[tail] & ~flush;
    assign dn_vld    = slot_vld[head] & ~flush;
    assign dn_data   = slot_data[head];
    assign push      = up_vld & up_rdy;
    assign pop       = dn_vld & dn_rdy;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_data[i] <= '0;
            end
        end else if (flush) begin
            slot_vld    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            almost_full <= 1'b0;
        end else begin
            // push and pop can never target the same slot: one needs it empty, the other full.
            if (push) begin
                slot_vld[tail]  <= 1'b1;
                slot_data[tail] <= up_data;
                tail            <= (tail == LAST_PTR) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                slot_vld[head] <= 1'b0;
                head           <= (head == LAST_PTR) ? '0 : head + 1'b1;
            end
            count       <= count_nxt;
            almost_full <= (count_nxt >= CNT_W'(AFULL_THRESH));
        end
    end

    a_head_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(head) < DEPTH);
    a_tail_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(tail) < DEPTH);
    a_cnt_range:  assert property (@(posedge clk) disable iff (!rst_n) 32'(count) <= DEPTH);
    a_no_under:   assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));
    a_no_over:    assert property (@(posedge clk) disable iff (!rst_n)
                                   !(push && !pop && 32'(count) == DEPTH));

endmodule

// File: tb/tb_fbeb_param.sv
// Directed self-checking bench for fbeb_param at DEPTH=5, DATA_WIDTH=8, AFULL_THRESH=4.
module tb_fbeb_param;

    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          up_vld;
    logic          up_rdy;
    logic [W-1:0]  up_data;
    logic          dn_vld;
    logic          dn_rdy;
    logic [W-1:0]  dn_data;
    logic [CW-1:0] count;
    logic          almost_full;

    int errors = 0;
    int checks = 0;

    fbeb_param #(.DATA_WIDTH(W), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .up_vld      (up_vld),
        .up_rdy      (up_rdy),
        .up_data     (up_data),
        .dn_vld      (dn_vld),
        .dn_rdy      (dn_rdy),
        .dn_data     (dn_data),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; up_vld = 1'b0; dn_rdy = 1'b0; up_data = '0;
        #3;
        checks++; if (dn_vld !== 1'b0) begin errors++; $display("FAIL reset_dn_vld got=%b exp=0", dn_vld); end
        checks++; if (up_rdy !== 1'b1) begin errors++; $display("FAIL reset_up_rdy got=%b exp=1", up_rdy); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
        checks++; if (dn_data !== '0) begin errors++; $display("FAIL reset_dn_data got=%h exp=00", dn_data); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        logic [W-1:0] exp_d;
        up_vld = 1'b1; dn_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = W'((i + 1) * 8'h11);
            up_data = exp_d;
            #1;
            checks++; if (up_rdy !== 1'b1) begin errors++; $display("FAIL fill_up_rdy[%0d] got=%b exp=1", i, up_rdy); end
            step();
            checks++; if (count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_afull[%0d] got=%b exp=%b", i, almost_full, (i + 1 >= AF)); end
        end
        checks++; if (up_rdy !== 1'b0) begin errors++; $display("FAIL full_up_rdy got=%b exp=0", up_rdy); end
        up_vld = 1'b0; dn_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = W'((i + 1) * 8'h11);
            #1;
            checks++; if (dn_vld !== 1'b1 || dn_data !== exp_d) begin errors++; $display("FAIL drain[%0d] got=%b/%h exp=1/%h", i, dn_vld, dn_data, exp_d); end
            step();
        end
        checks++; if (dn_vld !== 1'b0) begin errors++; $display("FAIL drain_empty_vld got=%b exp=0", dn_vld); end
        checks++; if (count !== '0) begin errors++; $display("FAIL drain_count got=%0d exp=0", count); end
        dn_rdy = 1'b0;
    endtask

    task automatic test_stream();
        up_vld = 1'b1; dn_rdy = 1'b1;
        for (int k = 0; k < 64; k++) begin
            up_data = W'(k);
            #1;
            if (k == 0) begin
                checks++; if (dn_vld !== 1'b0) begin errors++; $display("FAIL stream_first_vld got=%b exp=0", dn_vld); end
            end else begin
                checks++; if (dn_vld !== 1'b1 || dn_data !== W'(k - 1)) begin errors++; $display("FAIL stream[%0d] got=%b/%h exp=1/%h", k, dn_vld, dn_data, W'(k - 1)); end
            end
            checks++; if (up_rdy !== 1'b1) begin errors++; $display("FAIL stream_up_rdy[%0d] got=%b exp=1", k, up_rdy); end
            step();
            checks++; if (count !== CW'(1)) begin errors++; $display("FAIL stream_count[%0d] got=%0d exp=1", k, count); end
        end
        up_vld = 1'b0;
        #1;
        checks++; if (dn_vld !== 1'b1 || dn_data !== 8'h3F) begin errors++; $display("FAIL stream_last got=%b/%h exp=1/3f", dn_vld, dn_data); end
        step();
        checks++; if (count !== '0 || dn_vld !== 1'b0) begin errors++; $display("FAIL stream_end got=%0d/%b exp=0/0", count, dn_vld); end
        dn_rdy = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [W-1:0] exp_q [6];
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h99};
        up_vld = 1'b1; dn_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            up_data = exp_q[i];
            step();
        end
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL fullpop_fill got=%0d exp=5", count); end
        up_data = 8'h99;
        dn_rdy = 1'b1;
        #1;
        checks++; if (up_rdy !== 1'b0) begin errors++; $display("FAIL iso_rdy_hi got=%b exp=0", up_rdy); end
        dn_rdy = 1'b0;
        #1;
        checks++; if (up_rdy !== 1'b0) begin errors++; $display("FAIL iso_rdy_lo got=%b exp=0", up_rdy); end
        dn_rdy = 1'b1;
        #1;
        checks++; if (dn_vld !== 1'b1 || dn_data !== 8'h21) begin errors++; $display("FAIL fullpop_out0 got=%b/%h exp=1/21", dn_vld, dn_data); end
        step();
        checks++; if (count !== CW'(4) || up_rdy !== 1'b1) begin errors++; $display("FAIL fullpop_after got=%0d/%b exp=4/1", count, up_rdy); end
        checks++; if (dn_data !== 8'h22) begin errors++; $display("FAIL fullpop_out1 got=%h exp=22", dn_data); end
        step();
        checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fullpop_steady got=%0d exp=4", count); end
        up_vld = 1'b0;
        for (int i = 2; i < 6; i++) begin
            #1;
            checks++; if (dn_vld !== 1'b1 || dn_data !== exp_q[i]) begin errors++; $display("FAIL fullpop_drain[%0d] got=%b/%h exp=1/%h", i, dn_vld, dn_data, exp_q[i]); end
            step();
        end
        checks++; if (count !== '0) begin errors++; $display("FAIL fullpop_empty got=%0d exp=0", count); end
        dn_rdy = 1'b0;
    endtask

    task automatic test_flush();
        up_vld = 1'b1; dn_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up_data = W'(8'h31 + i);
            step();
        end
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_load got=%0d exp=3", count); end
        flush = 1'b1; dn_rdy = 1'b1; up_data = 8'h77;
        #1;
        checks++; if (up_rdy !== 1'b0 || dn_vld !== 1'b0) begin errors++; $display("FAIL flush_block got=%b/%b exp=0/0", up_rdy, dn_vld); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (count !== '0 || dn_vld !== 1'b0 || up_rdy !== 1'b1 || almost_full !== 1'b0)
            begin errors++; $display("FAIL flush_after got=%0d/%b/%b/%b exp=0/0/1/0", count, dn_vld, up_rdy, almost_full); end
        dn_rdy = 1'b0; up_data = 8'hA5;
        step();
        up_vld = 1'b0;
        checks++; if (dn_vld !== 1'b1 || dn_data !== 8'hA5) begin errors++; $display("FAIL flush_first got=%b/%h exp=1/a5", dn_vld, dn_data); end
        flush = 1'b1; up_vld = 1'b1; dn_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (count !== '0 || up_rdy !== 1'b0 || dn_vld !== 1'b0) begin errors++; $display("FAIL flush_hold[%0d] got=%0d/%b/%b exp=0/0/0", i, count, up_rdy, dn_vld); end
        end
        flush = 1'b0; up_vld = 1'b0; dn_rdy = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] q [$];
        logic         m_push, m_pop;
        logic [W-1:0] nd;
        for (int c = 0; c < 400; c++) begin
            up_vld = 1'($urandom_range(0, 1));
            dn_rdy = 1'($urandom_range(0, 1));
            nd = W'($urandom);
            up_data = nd;
            #1;
            checks++; if (up_rdy !== (q.size() < DEPTH)) begin errors++; $display("FAIL bp_up_rdy[%0d] got=%b exp=%b", c, up_rdy, (q.size() < DEPTH)); end
            checks++; if (dn_vld !== (q.size() > 0)) begin errors++; $display("FAIL bp_dn_vld[%0d] got=%b exp=%b", c, dn_vld, (q.size() > 0)); end
            if (q.size() > 0) begin
                checks++; if (dn_data !== q[0]) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=%h", c, dn_data, q[0]); end
            end
            checks++; if (count !== CW'(q.size())) begin errors++; $display("FAIL bp_count[%0d] got=%0d exp=%0d", c, count, q.size()); end
            checks++; if (almost_full !== (q.size() >= AF)) begin errors++; $display("FAIL bp_afull[%0d] got=%b exp=%b", c, almost_full, (q.size() >= AF)); end
            m_push = up_vld && (q.size() < DEPTH);
            m_pop  = dn_rdy && (q.size() > 0);
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(nd);
            step();
        end
        up_vld = 1'b0; dn_rdy = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        checks++; if (count !== '0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", count); end
        dn_rdy = 1'b0;
    endtask

    task automatic test_async_reset();
        up_vld = 1'b1; dn_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_data = W'(8'h41 + i);
            step();
        end
        checks++; if (count !== CW'(4) || almost_full !== 1'b1) begin errors++; $display("FAIL ar_load got=%0d/%b exp=4/1", count, almost_full); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (dn_vld !== 1'b0 || count !== '0 || almost_full !== 1'b0 || up_rdy !== 1'b1)
            begin errors++; $display("FAIL ar_immediate got=%b/%0d/%b/%b exp=0/0/0/1", dn_vld, count, almost_full, up_rdy); end
        #2;
        rst_n = 1'b1;
        up_data = 8'h5A;
        step();
        up_vld = 1'b0;
        checks++; if (dn_vld !== 1'b1 || dn_data !== 8'h5A) begin errors++; $display("FAIL ar_first got=%b/%h exp=1/5a", dn_vld, dn_data); end
        dn_rdy = 1'b1;
        step();
        checks++; if (count !== '0) begin errors++; $display("FAIL ar_end got=%0d exp=0", count); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_pop();
        test_flush();
        test_backpressure();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fbeb_param.md
Name: fbeb_param

Overview:
Parametrised full-bandwidth elastic buffer. It stores DEPTH entries of DATA_WIDTH bits in DEPTH single-entry slots, selected round-robin by a tail pointer (write) and a head pointer (read). It sustains one transfer per cycle in each direction, and upstream ready has no combinational path from downstream ready. It adds occupancy count, an almost-full flag and synchronous flush, and sits as the standard pipeline decoupling stage between valid/ready producers and consumers.

Parameters:
- DATA_WIDTH, 8, payload width in bits (>=1).
- DEPTH, 5, number of storage slots (>=2; any integer, not required to be a power of 2).
- AFULL_THRESH, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH).
- PTR_W, $clog2(DEPTH), derived; pointer width; not for override.
- CNT_W, $clog2(DEPTH+1), derived; count width; not for override.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset.
- flush  in  1  synchronous clear of all stored entries.
- up_vld  in  1  upstream valid.
- up_rdy  out  1  upstream ready.
- up_data  in  DATA_WIDTH  upstream payload.
- dn_vld  out  1  downstream valid.
- dn_rdy  in  1  downstream ready.
- dn_data  out  DATA_WIDTH  downstream payload.
- count  out  CNT_W  current occupancy (registered).
- almost_full  out  1  count >= AFULL_THRESH (registered).

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset, all slot valid bits = 0, slot data = 0, head = tail = 0, count = 0, almost_full = 0.
- Outputs in reset: dn_vld = 0, dn_data = 0, up_rdy = 1.
- Handshakes: push = up_vld & up_rdy; pop = dn_vld & dn_rdy.
- Slot state: slot_vld[i] and slot_data[i] are flops. On push, slot[tail] is loaded with up_data and slot_vld[tail] is set. On pop, slot_vld[head] is cleared.
- Output decode:
  - up_rdy = ~slot_vld[tail] & ~flush.
  - dn_vld = slot_vld[head] & ~flush.
  - dn_data = slot_data[head] (mux from flops; dn_data is not cleared on pop).
- Ready isolation: up_rdy depends only on flops and flush, never on dn_rdy. dn_vld never depends on up_vld.
- Pointer advance:
  - tail advances on push, head advances on pop.
  - Wrap is explicit: if ptr == DEPTH-1 then ptr <= 0, else ptr <= ptr+1.
  - Pointer values >= DEPTH are unreachable; an assertion flags them.
- Latency: data pushed in cycle N is visible at dn_vld/dn_data in cycle N+1. There is no same-cycle bypass.
- Throughput: simultaneous push and pop each cycle sustains 1 item/cycle at any occupancy 1..DEPTH-1.
- Full (count == DEPTH): up_rdy = 0. A pop in that cycle frees a slot, but up_rdy rises only in the next cycle.
- Empty (count == 0): dn_vld = 0. A push in that cycle is visible next cycle.
- count update: count <= count + push - pop. Simultaneous push and pop leaves count unchanged. count never exceeds DEPTH or underflows; assertions cover both.
- almost_full: registered, computed from the next-state count, so it is coincident with count.
- Flush:
  - When flush = 1 in cycle N, up_rdy and dn_vld are forced 0 in cycle N, so no handshake completes.
  - In cycle N+1, all slot_vld = 0, head = tail = 0, count = 0, almost_full = 0.
  - Flush has priority over push and pop.
  - Flush held for multiple cycles keeps the buffer empty and blocked.
- Reset mid-operation: asynchronously returns all state to the reset values, regardless of pending handshakes.
- Ordering: strict FIFO order. No data loss or duplication under any vld/rdy pattern.

Test Plan:
- Fill/drain (DEPTH=5, W=8): push 0x11..0x55 with dn_rdy=0 -> count 1,2,3,4,5; almost_full rises with count=4; up_rdy=0 after the 5th push. Then dn_rdy=1 -> outputs 0x11..0x55 in order on 5 consecutive cycles, dn_vld=0 after, count=0.
- Streaming: up_vld=dn_rdy=1 continuously, data = incrementing 0x00..0x3F -> first dn_vld one cycle after the first push; then 1 item/cycle with no bubbles; count steady at 1; order preserved through at least 12 pointer wraps.
- Full with simultaneous pop: fill to 5, then hold up_vld=1 and dn_rdy=1 -> up_rdy=0 in the pop cycle and 1 the cycle after; count goes 5->4->4 (steady state); a formal or assertion check confirms up_rdy never depends on dn_rdy.
- Flush: load 3 items (count=3), assert flush for 1 cycle with up_vld=dn_rdy=1 -> no handshake in the flush cycle; next cycle count=0, dn_vld=0, up_rdy=1; the next push of 0xA5 appears as the first output.
- Random backpressure: random up_vld/dn_rdy at 50% each for 10k cycles with DEPTH=3 and DEPTH=7, W=16 -> scoreboard matches in order; count always in 0..DEPTH; almost_full == (count >= AFULL_THRESH) every cycle.
- Async reset mid-stream: assert rst_n=0 between clock edges with count=4 -> dn_vld=0, count=0, almost_full=0, up_rdy=1 immediately. After release, the first push of 0x5A is output 1 cycle later.
